// File: rtl/processador_pkg.sv
// Shared definitions for the multicycle processor: opcodes, FSM state codes and
// instruction field extraction helpers that work for any WIDTH/NREGS combination.
package processador_pkg;

  typedef logic [1:0] state_t;

  localparam state_t T0 = 2'd0;
  localparam state_t T1 = 2'd1;
  localparam state_t T2 = 2'd2;
  localparam state_t T3 = 2'd3;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_MVI = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // Instruction word is zero-extended to 32 bits so one helper serves every WIDTH.
  function automatic logic [3:0] op_field(input logic [31:0] w, input int unsigned width);
    return 4'(w >> (width - 4));
  endfunction

  function automatic logic [3:0] rx_field(input logic [31:0] w, input int unsigned width,
                                          input int unsigned nregs);
    int unsigned rw;
    rw = $clog2(nregs);
    return 4'((w >> (width - 4 - rw)) & ((32'd1 << rw) - 32'd1));
  endfunction

  function automatic logic [3:0] ry_field(input logic [31:0] w, input int unsigned width,
                                          input int unsigned nregs);
    int unsigned rw;
    rw = $clog2(nregs);
    return 4'((w >> (width - 4 - 2 * rw)) & ((32'd1 << rw) - 32'd1));
  endfunction

endpackage

// File: rtl/processador_alu.sv
// Combinational ALU: A is the latched first operand, B comes straight off the bus.
// C is only meaningful for add (carry) and sub (borrow); the caller decides when to latch it.
module processador_alu
  import processador_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c
);

  always_comb begin
    result = '0;
    c      = 1'b0;
    case (op)
      OP_ADD: {c, result} = {1'b0, a} + {1'b0, b};
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL: result = b << 1;
      OP_SHR: result = b >> 1;
      default: result = '0;
    endcase
    z = (result == '0);
  end

endmodule

// File: rtl/processador_multiciclo.sv
// Multicycle processor core: one shared bus, register array, A/G ALU latches,
// and a 4-state sequencer (T0 fetch, T1 move/operand A, T2 execute, T3 writeback).
module processador_multiciclo
  import processador_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             run,
  input  logic [WIDTH-1:0] iin,
  output logic             done,
  output logic [WIDTH-1:0] bus,
  output logic             flag_z,
  output logic             flag_c
);

  localparam int RW = $clog2(NREGS);

  state_t           state, state_nx;
  logic [WIDTH-1:0] ir, a, g, bus_mux;
  logic [WIDTH-1:0] regs [NREGS];
  logic [3:0]       op;
  logic [RW-1:0]    rx, ry;
  logic             is_alu;
  logic [WIDTH-1:0] alu_res;
  logic             alu_z, alu_c;

  assign op     = op_field(32'(ir), WIDTH);
  assign rx     = RW'(rx_field(32'(ir), WIDTH, NREGS));
  assign ry     = RW'(ry_field(32'(ir), WIDTH, NREGS));
  assign is_alu = (op >= OP_ADD) && (op <= OP_SHR);

  always_comb begin
    bus_mux = '0;
    case (state)
      T0: bus_mux = iin;
      T1: begin
        if (op == OP_MV)       bus_mux = regs[ry];
        else if (op == OP_MVI) bus_mux = iin;
        else if (is_alu)       bus_mux = regs[rx];
      end
      T2: bus_mux = regs[ry];
      T3: bus_mux = g;
      default: bus_mux = '0;
    endcase
  end

  // Gating with resetn makes the bus read zero immediately on reset assertion,
  // even while sitting in T0 where it would otherwise mirror iin.
  assign bus = resetn ? bus_mux : '0;

  always_comb begin
    state_nx = state;
    case (state)
      T0: state_nx = run ? T1 : T0;
      T1: state_nx = is_alu ? T2 : T0;
      T2: state_nx = T3;
      T3: state_nx = T0;
      default: state_nx = T0;
    endcase
  end

  assign done = ((state == T1) && !is_alu) || (state == T3);

  processador_alu #(.WIDTH(WIDTH)) u_alu (
    .op     (op),
    .a      (a),
    .b      (bus_mux),
    .result (alu_res),
    .z      (alu_z),
    .c      (alu_c)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state  <= T0;
      ir     <= '0;
      a      <= '0;
      g      <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      regs   <= '{default: '0};
    end else begin
      state <= state_nx;
      case (state)
        T0: if (run) ir <= iin;
        T1: begin
          if (op == OP_MV || op == OP_MVI) regs[rx] <= bus_mux;
          else if (is_alu)                 a <= bus_mux;
        end
        T2: begin
          g      <= alu_res;
          flag_z <= alu_z;
          if (op == OP_ADD || op == OP_SUB) flag_c <= alu_c;
        end
        T3: regs[rx] <= g;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_processador_multiciclo.sv
// Directed bench: a 16-bit/8-register core and an 8-bit/4-register core, each
// driven instruction by instruction with hand-computed bus, done and flag values.
module tb_processador_multiciclo;

  logic        clock = 1'b0;
  logic        resetn;
  logic        run;
  logic        sel;
  logic [15:0] iin;

  logic        done_a, fz_a, fc_a;
  logic [15:0] bus_a;
  logic        done_b, fz_b, fc_b;
  logic [7:0]  bus_b;

  logic        run_a, run_b;
  logic [7:0]  iin_b;
  logic        dn, fz, fc;
  logic [15:0] bus_o;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  assign run_a = run & ~sel;
  assign run_b = run & sel;
  assign iin_b = iin[7:0];
  assign dn    = sel ? done_b : done_a;
  assign fz    = sel ? fz_b : fz_a;
  assign fc    = sel ? fc_b : fc_a;
  assign bus_o = sel ? {8'h00, bus_b} : bus_a;

  processador_multiciclo #(.WIDTH(16), .NREGS(8)) dut_a (
    .clock  (clock),
    .resetn (resetn),
    .run    (run_a),
    .iin    (iin),
    .done   (done_a),
    .bus    (bus_a),
    .flag_z (fz_a),
    .flag_c (fc_a)
  );

  processador_multiciclo #(.WIDTH(8), .NREGS(4)) dut_b (
    .clock  (clock),
    .resetn (resetn),
    .run    (run_b),
    .iin    (iin_b),
    .done   (done_b),
    .bus    (bus_b),
    .flag_z (fz_b),
    .flag_c (fc_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] e16(input logic [3:0] op, input logic [2:0] rx, input logic [2:0] ry);
    return {op, rx, ry, 6'b0};
  endfunction

  function automatic logic [15:0] e8(input logic [3:0] op, input logic [1:0] rx, input logic [1:0] ry);
    return {8'h00, op, rx, ry};
  endfunction

  // Entered in T0 just after an edge; leaves run high so the next call follows with no gap.
  task automatic ins(input string tag, input logic [15:0] w, input logic [15:0] imm,
                     input bit alu, output logic [15:0] b1, output logic [15:0] b3);
    b3  = '0;
    iin = w;
    run = 1'b1;
    check({tag, "/t0_done"}, 32'(dn), 32'd0);
    step();
    iin = imm;
    #1;
    b1 = bus_o;
    check({tag, "/t1_done"}, 32'(dn), alu ? 32'd0 : 32'd1);
    if (alu) begin
      step();
      check({tag, "/t2_done"}, 32'(dn), 32'd0);
      step();
      b3 = bus_o;
      check({tag, "/t3_done"}, 32'(dn), 32'd1);
    end
    step();
  endtask

  logic [15:0] b1, b3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    sel    = 1'b0;
    run    = 1'b0;
    iin    = 16'h1234;
    resetn = 1'b0;
    step();
    step();
    check("rst_bus", 32'(bus_o), 32'h0);
    check("rst_done", 32'(dn), 32'h0);
    check("rst_flags", {30'b0, fz, fc}, 32'h0);
    resetn = 1'b1;
    #1;
    check("t0_bus_iin", 32'(bus_o), 32'h1234);

    // test 1
    ins("mvi_r0", 16'h1000, 16'h001C, 1'b0, b1, b3);
    check("mvi_r0_bus", 32'(b1), 32'h001C);
    ins("mv_r1_r0", e16(4'd0, 3'd1, 3'd0), 16'h0, 1'b0, b1, b3);
    check("mv_r1_bus", 32'(b1), 32'h001C);

    // test 2
    ins("mvi_r2", e16(4'd1, 3'd2, 3'd0), 16'hFFFF, 1'b0, b1, b3);
    ins("mvi_r3", e16(4'd1, 3'd3, 3'd0), 16'h0001, 1'b0, b1, b3);
    ins("add_r2_r3", e16(4'd2, 3'd2, 3'd3), 16'h0, 1'b1, b1, b3);
    check("add_t1_bus", 32'(b1), 32'hFFFF);
    check("add_res", 32'(b3), 32'h0000);
    check("add_flags", {30'b0, fz, fc}, 32'h3);

    // test 3
    ins("mvi_r2b", e16(4'd1, 3'd2, 3'd0), 16'h0002, 1'b0, b1, b3);
    ins("sub_r3_r2", e16(4'd3, 3'd3, 3'd2), 16'h0, 1'b1, b1, b3);
    check("sub_res", 32'(b3), 32'hFFFF);
    check("sub_flags", {30'b0, fz, fc}, 32'h1);
    ins("slt_r3_r0", e16(4'd7, 3'd3, 3'd0), 16'h0, 1'b1, b1, b3);
    check("slt_res", 32'(b3), 32'h0001);
    check("slt_flags", {30'b0, fz, fc}, 32'h1);

    // test 4
    ins("nop", 16'hF000, 16'h0, 1'b0, b1, b3);
    check("nop_flags", {30'b0, fz, fc}, 32'h1);
    ins("rd_r3", e16(4'd0, 3'd3, 3'd3), 16'h0, 1'b0, b1, b3);
    check("rd_r3_val", 32'(b1), 32'h0001);
    ins("mvi_r4", e16(4'd1, 3'd4, 3'd0), 16'h00F0, 1'b0, b1, b3);
    ins("mvi_r5", e16(4'd1, 3'd5, 3'd0), 16'h0F3C, 1'b0, b1, b3);
    ins("and_r4_r5", e16(4'd4, 3'd4, 3'd5), 16'h0, 1'b1, b1, b3);
    check("and_res", 32'(b3), 32'h0030);
    ins("or_r5_r4", e16(4'd5, 3'd5, 3'd4), 16'h0, 1'b1, b1, b3);
    check("or_res", 32'(b3), 32'h0F3C);
    ins("xor_r4_r4", e16(4'd6, 3'd4, 3'd4), 16'h0, 1'b1, b1, b3);
    check("xor_res", 32'(b3), 32'h0000);
    check("xor_flags", {30'b0, fz, fc}, 32'h3);
    ins("add_r0_r0", e16(4'd2, 3'd0, 3'd0), 16'h0, 1'b1, b1, b3);
    check("dbl_res", 32'(b3), 32'h0038);
    check("dbl_flags", {30'b0, fz, fc}, 32'h0);
    ins("sub_r1_r1", e16(4'd3, 3'd1, 3'd1), 16'h0, 1'b1, b1, b3);
    check("self_sub_res", 32'(b3), 32'h0000);
    check("self_sub_flags", {30'b0, fz, fc}, 32'h2);
    ins("shr_r6_r5", e16(4'd9, 3'd6, 3'd5), 16'h0, 1'b1, b1, b3);
    check("shr_res", 32'(b3), 32'h079E);
    ins("shl_r7_r5", e16(4'd8, 3'd7, 3'd5), 16'h0, 1'b1, b1, b3);
    check("shl_res", 32'(b3), 32'h1E78);
    ins("sub_r0_r7", e16(4'd3, 3'd0, 3'd7), 16'h0, 1'b1, b1, b3);
    check("borrow_res", 32'(b3), 32'hE1C0);
    check("borrow_flags", {30'b0, fz, fc}, 32'h1);

    run = 1'b0;
    iin = 16'hABCD;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_done", 32'(dn), 32'h0);
      check("idle_bus", 32'(bus_o), 32'hABCD);
    end

    // test 5: reset during T2 of add R0,R1
    iin = e16(4'd2, 3'd0, 3'd1);
    run = 1'b1;
    step();
    run = 1'b0;
    step();
    resetn = 1'b0;
    #1;
    check("midrst_bus", 32'(bus_o), 32'h0);
    check("midrst_done", 32'(dn), 32'h0);
    check("midrst_flags", {30'b0, fz, fc}, 32'h0);
    step();
    resetn = 1'b1;
    iin = 16'h5A5A;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_rst_done", 32'(dn), 32'h0);
      check("post_rst_bus", 32'(bus_o), 32'h5A5A);
    end
    ins("rd_r0", e16(4'd0, 3'd0, 3'd0), 16'h0, 1'b0, b1, b3);
    check("rd_r0_val", 32'(b1), 32'h0000);
    ins("rd_r7", e16(4'd0, 3'd7, 3'd7), 16'h0, 1'b0, b1, b3);
    check("rd_r7_val", 32'(b1), 32'h0000);
    run = 1'b0;
    step();

    // test 6: 8-bit, 4-register core
    sel = 1'b1;
    #1;
    check("b_rst_flags", {30'b0, fz, fc}, 32'h0);
    ins("b_mvi_r2", e8(4'd1, 2'd2, 2'd0), 16'h0001, 1'b0, b1, b3);
    check("b_mvi_bus", 32'(b1), 32'h0001);
    ins("b_mvi_r3", e8(4'd1, 2'd3, 2'd0), 16'h0002, 1'b0, b1, b3);
    ins("b_sub", e8(4'd3, 2'd2, 2'd3), 16'h0, 1'b1, b1, b3);
    check("b_sub_res", 32'(b3), 32'h00FF);
    check("b_sub_flags", {30'b0, fz, fc}, 32'h1);
    ins("b_mvi_r1", e8(4'd1, 2'd1, 2'd0), 16'h0080, 1'b0, b1, b3);
    ins("b_shl", e8(4'd8, 2'd1, 2'd1), 16'h0, 1'b1, b1, b3);
    check("b_shl_res", 32'(b3), 32'h0000);
    check("b_shl_flags", {30'b0, fz, fc}, 32'h3);
    ins("b_mvi_r0", e8(4'd1, 2'd0, 2'd0), 16'h0080, 1'b0, b1, b3);
    ins("b_shr", e8(4'd9, 2'd0, 2'd0), 16'h0, 1'b1, b1, b3);
    check("b_shr_res", 32'(b3), 32'h0040);
    check("b_shr_flags", {30'b0, fz, fc}, 32'h1);
    ins("b_rd_r1", e8(4'd0, 2'd1, 2'd1), 16'h0, 1'b0, b1, b3);
    check("b_rd_r1_val", 32'(b1), 32'h0000);
    run = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
